time_set_editor: RTL and testbench

- Time-setting editor; the writer side of the blinking digit display multiplexer.
- Turns button presses into a BCD time edit: cursor position, per-digit increment and decrement, and commit.
- Outputs the 32-bit display string and blink cursor index consumed by the display scanner, plus a one-cycle load strobe with the new time for the clock core.

---
 rtl/time_set_editor_pkg.sv | 43 ++++
 rtl/time_set_editor_button_conditioner.sv | 72 +++++++
 rtl/time_set_editor.sv | 147 ++++++++++++++
 tb/tb_time_set_editor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_editor_pkg.sv
// Shared types and constants for the time-set editor: FSM states, digit positions
// and per-digit limits of the BCD HHMMSS edit buffer.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] HR_T  = 3'd5;
  localparam logic [2:0] HR_U  = 3'd4;
  localparam logic [2:0] MIN_T = 3'd3;
  localparam logic [2:0] MIN_U = 3'd2;
  localparam logic [2:0] SEC_T = 3'd1;
  localparam logic [2:0] SEC_U = 3'd0;

  localparam logic [3:0] HR_T_MAX       = 4'd2;
  localparam logic [3:0] HR_U_MAX       = 4'd9;
  localparam logic [3:0] MIN_T_MAX      = 4'd5;
  localparam logic [3:0] MIN_U_MAX      = 4'd9;
  localparam logic [3:0] SEC_T_MAX      = 4'd5;
  localparam logic [3:0] SEC_U_MAX      = 4'd9;
  localparam logic [3:0] HR_U_MAX_AT_20 = 4'd3;

  localparam logic [4:0] CURSOR_NONE = 5'd31;

  // Upper bound of the digit at pos; hour units depends on the current hour tens.
  function automatic logic [3:0] digit_max(input logic [2:0] pos, input logic [3:0] hr_tens);
    logic [3:0] lim;
    case (pos)
      HR_T:    lim = HR_T_MAX;
      HR_U:    lim = (hr_tens == 4'd2) ? HR_U_MAX_AT_20 : HR_U_MAX;
      MIN_T:   lim = MIN_T_MAX;
      MIN_U:   lim = MIN_U_MAX;
      SEC_T:   lim = SEC_T_MAX;
      SEC_U:   lim = SEC_U_MAX;
      default: lim = 4'd9;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/time_set_editor_button_conditioner.sv
// Raw button to single action pulse: 2-flop synchroniser, optional debounce
// (TIME_SET_DEBOUNCE_EN), and a registered rising-edge detector.
module button_conditioner #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic pulse_d;
  logic level_s;

`ifdef TIME_SET_DEBOUNCE_EN
  logic        deb_q, deb_d;
  logic [19:0] cnt_q, cnt_d;

  // Debounced level follows the synchronised input only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = 20'd0;
    if (sync2_q != deb_q) begin
      if (cnt_q >= (DEBOUNCE_CYCLES - 20'd1)) begin
        deb_d = sync2_q;
        cnt_d = 20'd0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end else begin
      cnt_d = 20'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= 1'b0;
      cnt_q <= 20'd0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_s = deb_q;
`else
  assign level_s = sync2_q;
`endif

  always_comb begin
    pulse_d = level_s & ~prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level_s;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_editor.sv
// BCD time-setting editor: buttons move a cursor and edit digits, enter commits.
// Optional input debounce is enabled with the TIME_SET_DEBOUNCE_EN macro.
module time_set_editor
  import time_set_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [3:0]  BLANK_CODE      = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_enter,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [23:0] time_in,
  output logic [31:0] disp_string,
  output logic [4:0]  cursor,
  output logic        editing,
  output logic        time_load,
  output logic [23:0] time_out
);

  logic p_enter, p_up, p_down, p_left, p_right;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .btn_raw(btn_enter), .pulse(p_enter));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .btn_raw(btn_up), .pulse(p_up));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .reset(reset), .btn_raw(btn_down), .pulse(p_down));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .reset(reset), .btn_raw(btn_left), .pulse(p_left));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .reset(reset), .btn_raw(btn_right), .pulse(p_right));

  state_t      state_q, state_d;
  logic [23:0] buf_q, buf_d;
  logic [4:0]  cursor_q, cursor_d;
  logic        editing_q, editing_d;
  logic        load_q, load_d;
  logic [23:0] out_q, out_d;

  logic        act_enter, act_up, act_down, act_left, act_right;
  logic [2:0]  pos_s;
  logic [3:0]  digit_s, lim_s, new_digit_s;

  // One action per cycle: enter > up > down > left > right.
  always_comb begin
    act_enter = p_enter;
    act_up    = p_up    & ~p_enter;
    act_down  = p_down  & ~p_enter & ~p_up;
    act_left  = p_left  & ~p_enter & ~p_up & ~p_down;
    act_right = p_right & ~p_enter & ~p_up & ~p_down & ~p_left;
  end

  // Next-state, edit buffer and output register inputs.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cursor_d    = cursor_q;
    out_d       = out_q;
    pos_s       = cursor_q[2:0];
    digit_s     = buf_q[{pos_s, 2'b00} +: 4];
    lim_s       = digit_max(pos_s, buf_q[23:20]);
    new_digit_s = digit_s;

    case (state_q)
      IDLE: begin
        buf_d    = time_in;
        cursor_d = CURSOR_NONE;
        if (act_enter) begin
          state_d  = EDIT;
          cursor_d = {2'b00, HR_T};
        end else begin
          state_d = IDLE;
        end
      end
      EDIT: begin
        if (act_enter) begin
          state_d = COMMIT;
        end else if (act_up || act_down) begin
          // Out-of-range digits wrap to 0 on up and snap to the limit on down.
          if (act_up) begin
            new_digit_s = (digit_s >= lim_s) ? 4'd0 : digit_s + 4'd1;
          end else begin
            new_digit_s = ((digit_s == 4'd0) || (digit_s > lim_s)) ? lim_s : digit_s - 4'd1;
          end
          buf_d[{pos_s, 2'b00} +: 4] = new_digit_s;
          if ((pos_s == HR_T) && (new_digit_s == 4'd2) && (buf_q[19:16] > HR_U_MAX_AT_20)) begin
            buf_d[19:16] = HR_U_MAX_AT_20;
          end else begin
            buf_d[19:16] = buf_d[19:16];
          end
        end else if (act_left) begin
          cursor_d = (cursor_q == 5'd5) ? 5'd0 : cursor_q + 5'd1;
        end else if (act_right) begin
          cursor_d = (cursor_q == 5'd0) ? 5'd5 : cursor_q - 5'd1;
        end else begin
          state_d = EDIT;
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        cursor_d = CURSOR_NONE;
      end
      default: begin
        state_d  = IDLE;
        cursor_d = CURSOR_NONE;
      end
    endcase

    editing_d = (state_d == EDIT);
    load_d    = (state_d == COMMIT);
    if (load_d) begin
      out_d = buf_q;
    end else begin
      out_d = out_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= 24'h000000;
      cursor_q  <= CURSOR_NONE;
      editing_q <= 1'b0;
      load_q    <= 1'b0;
      out_q     <= 24'h000000;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cursor_q  <= cursor_d;
      editing_q <= editing_d;
      load_q    <= load_d;
      out_q     <= out_d;
    end
  end

  assign disp_string = {BLANK_CODE, BLANK_CODE, buf_q};
  assign cursor      = cursor_q;
  assign editing     = editing_q;
  assign time_load   = load_q;
  assign time_out    = out_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Self-checking bench for time_set_editor: directed plan steps plus random button
// sequences checked against a digit-array model of the editor.
module tb_time_set_editor;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_enter, btn_up, btn_down, btn_left, btn_right;
  logic [23:0] time_in;
  logic [31:0] disp_string;
  logic [4:0]  cursor;
  logic        editing, time_load;
  logic [23:0] time_out;

  time_set_editor #(.DEBOUNCE_CYCLES(20'd4), .BLANK_CODE(4'hA)) dut (
    .clk(clk), .reset(reset),
    .btn_enter(btn_enter), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .time_in(time_in), .disp_string(disp_string), .cursor(cursor),
    .editing(editing), .time_load(time_load), .time_out(time_out));

  always #5 clk = ~clk;

`ifdef TIME_SET_DEBOUNCE_EN
  localparam int HOLD = 6;
  localparam int SETTLE = 14;
`else
  localparam int HOLD = 2;
  localparam int SETTLE = 8;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Observed commit strobes: cycles high and value seen on the last one.
  int          load_cnt = 0;
  logic [23:0] load_val = 24'h0;
  always @(negedge clk) begin
    if (time_load === 1'b1) begin
      load_cnt = load_cnt + 1;
      load_val = time_out;
    end
  end

  // Reference model: mode, cursor and six decimal digits.
  bit          medit = 1'b0;
  int          mcur = 31;
  logic [3:0]  md [6];
  int          exp_loads = 0;
  logic [23:0] exp_val = 24'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mbuf();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[i*4 +: 4] = md[i];
    return v;
  endfunction

  function automatic logic [3:0] mlim(input int p);
    if (p == 5) return 4'd2;
    if (p == 4) return (md[5] == 4'd2) ? 4'd3 : 4'd9;
    if (p == 3 || p == 1) return 4'd5;
    return 4'd9;
  endfunction

  task automatic track_time_in();
    for (int i = 0; i < 6; i++) md[i] = time_in[i*4 +: 4];
  endtask

  task automatic model_apply(input logic [4:0] m);
    logic [3:0] lim;
    if (!medit) begin
      if (m[0]) begin
        track_time_in();
        medit = 1'b1;
        mcur = 5;
      end
    end else if (m[0]) begin
      exp_loads++;
      exp_val = mbuf();
      medit = 1'b0;
      mcur = 31;
    end else if (m[1] || m[2]) begin
      lim = mlim(mcur);
      if (m[1]) md[mcur] = (md[mcur] >= lim) ? 4'd0 : md[mcur] + 4'd1;
      else md[mcur] = (md[mcur] == 4'd0 || md[mcur] > lim) ? lim : md[mcur] - 4'd1;
      if (mcur == 5 && md[5] == 4'd2 && md[4] > 4'd3) md[4] = 4'd3;
    end else if (m[3]) begin
      mcur = (mcur == 5) ? 0 : mcur + 1;
    end else if (m[4]) begin
      mcur = (mcur == 0) ? 5 : mcur - 1;
    end
    if (!medit) track_time_in();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".disp"}, disp_string, {8'hAA, mbuf()});
    check({tag, ".cursor"}, {27'd0, cursor}, medit ? mcur : 31);
    check({tag, ".editing"}, {31'd0, editing}, {31'd0, medit});
    check({tag, ".loads"}, load_cnt, exp_loads);
    if (exp_loads > 0) check({tag, ".time_out"}, {8'd0, load_val}, {8'd0, exp_val});
  endtask

  // mask bits: {right, left, down, up, enter}
  task automatic press(input logic [4:0] m, input string tag);
    @(posedge clk); #1;
    {btn_right, btn_left, btn_down, btn_up, btn_enter} = m;
    repeat (HOLD) @(posedge clk);
    #1 {btn_right, btn_left, btn_down, btn_up, btn_enter} = 5'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
    model_apply(m);
    check_model(tag);
  endtask

  task automatic check_disp(input string tag, input logic [31:0] exp);
    check(tag, disp_string, exp);
  endtask

  logic [23:0] rt;
  logic [4:0]  rm;
  int          r;

  initial begin
    reset = 1'b1;
    {btn_right, btn_left, btn_down, btn_up, btn_enter} = 5'b0;
    time_in = 24'h123456;
    repeat (2) @(posedge clk);
    #1;
    check("rst.disp", disp_string, 32'hAA000000);
    check("rst.cursor", {27'd0, cursor}, 32'd31);
    check("rst.editing", {31'd0, editing}, 32'd0);
    check("rst.load", {31'd0, time_load}, 32'd0);
    check("rst.time_out", {8'd0, time_out}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle.track", disp_string, 32'hAA123456);
    check("idle.cursor", {27'd0, cursor}, 32'd31);
    track_time_in();

`ifndef TIME_SET_DEBOUNCE_EN
    // Enter latency: editing rises on the 4th edge after the press is applied.
    @(posedge clk); #1 btn_enter = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat.before", {31'd0, editing}, 32'd0);
    @(posedge clk);
    #1 check("lat.after", {31'd0, editing}, 32'd1);
    btn_enter = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1 model_apply(5'b00001);
    check_model("lat");
`else
    press(5'b00001, "enter");
`endif
    check("edit.cursor5", {27'd0, cursor}, 32'd5);
    press(5'b00010, "up1"); check_disp("ht2", 32'hAA223456);
    press(5'b00010, "up2"); check_disp("ht0", 32'hAA023456);
    press(5'b00010, "up3"); check_disp("ht1", 32'hAA123456);
    press(5'b00010, "up4");
    press(5'b00010, "up5"); check_disp("ht0b", 32'hAA023456);
    press(5'b00100, "dn0"); check_disp("ht_dn", 32'hAA223456);
    press(5'b00001, "commit1");
    check("commit1.val", {8'd0, load_val}, 32'h00223456);

    time_in = 24'h190000;
    press(5'b00001, "enter190");
    press(5'b00010, "clamp"); check_disp("clamp.val", 32'hAA230000);
    for (int i = 0; i < 6; i++) press(5'b10000, "right");
    check("right.wrap", {27'd0, cursor}, 32'd5);
    press(5'b01000, "left.wrap"); check("left.wrap.c", {27'd0, cursor}, 32'd0);
    press(5'b00100, "d0");
    press(5'b01000, "l1"); press(5'b00100, "d1");
    press(5'b01000, "l2"); press(5'b00100, "d2");
    press(5'b01000, "l3"); press(5'b00100, "d3");
    check_disp("edit235959", 32'hAA235959);
    time_in = 24'h010203;
    press(5'b00001, "commit2");
    check("commit2.val", {8'd0, load_val}, 32'h00235959);
    check_disp("commit2.track", 32'hAA010203);

    // Enter and up together: commit wins, no digit change.
    press(5'b00001, "enter3");
    press(5'b00011, "enter_up");
    check("enter_up.val", {8'd0, load_val}, 32'h00010203);

    // Reset mid-edit abandons the edit.
    press(5'b00001, "enter4");
    press(5'b00010, "up_pre_rst");
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rstedit.editing", {31'd0, editing}, 32'd0);
    check("rstedit.cursor", {27'd0, cursor}, 32'd31);
    check("rstedit.load", {31'd0, time_load}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    medit = 1'b0; mcur = 31; track_time_in();
    repeat (SETTLE) @(posedge clk);
    #1 check_model("rstedit.after");

`ifdef TIME_SET_DEBOUNCE_EN
    press(5'b00001, "deb.enter");
    @(posedge clk); #1 btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1 check_model("deb.glitch");
    @(posedge clk); #1 btn_up = 1'b1;
    repeat (6) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1 model_apply(5'b00010);
    check_model("deb.press6");
`endif

    // Random button sequences, including invalid time_in digits.
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          rt = 24'($urandom);
        end else begin
          rt[23:20] = 4'($urandom_range(0, 2));
          rt[19:16] = 4'($urandom_range(0, (rt[23:20] == 4'd2) ? 3 : 9));
          rt[15:12] = 4'($urandom_range(0, 5));
          rt[11:8]  = 4'($urandom_range(0, 9));
          rt[7:4]   = 4'($urandom_range(0, 5));
          rt[3:0]   = 4'($urandom_range(0, 9));
        end
        time_in = rt;
      end
      if ($urandom_range(0, 4) == 0) begin
        rm = 5'($urandom_range(0, 31));
      end else begin
        r = $urandom_range(0, 9);
        rm = (r == 0) ? 5'b00001 : (r <= 3) ? 5'b00010 : (r <= 6) ? 5'b00100 :
             (r <= 8) ? 5'b01000 : 5'b10000;
      end
      press(rm, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
